// File: rtl/rr_arb_mux_src.sv
// Round-robin arbiter feeding a registered select/data/valid source for mux_bus_prm.
// Optional saturating transfer counter port cnt_o is enabled by defining RR_ARB_MUX_SRC_STAT_EN.
module rr_arb_mux_src #(
   parameter int SEL_WIDTH = 2,
   parameter int DAT_WIDTH = 2
) (
   input  logic                                      clk_i,
   input  logic                                      rst_i,
   input  logic [(2**SEL_WIDTH)-1:0]                 req_i,
   input  logic [(2**SEL_WIDTH)-1:0][DAT_WIDTH-1:0]  dat_i,
   output logic [(2**SEL_WIDTH)-1:0]                 gnt_o,
   output logic [SEL_WIDTH-1:0]                      sel_o,
   output logic [DAT_WIDTH-1:0]                      dat_o,
   output logic                                      vld_o,
   input  logic                                      rdy_i
`ifdef RR_ARB_MUX_SRC_STAT_EN
   ,
   output logic [15:0]                               cnt_o
`endif
);

   localparam int N = 2**SEL_WIDTH;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t               state;
   logic [SEL_WIDTH-1:0] ptr;
   logic [SEL_WIDTH-1:0] win_idx;
   logic [SEL_WIDTH-1:0] cand;
   logic                 win_found;
   logic                 load;
   logic                 grant;

   assign vld_o = (state == FULL);
   assign load  = (state == EMPTY) || rdy_i;
   assign grant = load && win_found && !rst_i;

   // Scan requesters starting at ptr; the modular add handles the wrap to index 0.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < N; i++) begin
         cand = ptr + SEL_WIDTH'(i);
         if (!win_found && req_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      gnt_o = '0;
      if (grant) gnt_o[win_idx] = 1'b1;
   end

   // Output register: refill on grant, empty when loading with no requester, hold under back-pressure.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= EMPTY;
         sel_o <= '0;
         dat_o <= '0;
         ptr   <= '0;
      end else if (load) begin
         if (win_found) begin
            state <= FULL;
            sel_o <= win_idx;
            dat_o <= dat_i[win_idx];
            ptr   <= win_idx + 1'b1;
         end else begin
            state <= EMPTY;
         end
      end
   end

`ifdef RR_ARB_MUX_SRC_STAT_EN
   // Counts downstream transfers and sticks at all-ones.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_o <= '0;
      end else if (vld_o && rdy_i && (cnt_o != 16'hFFFF)) begin
         cnt_o <= cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rr_arb_mux_src.sv
// Self-checking bench for rr_arb_mux_src: a queue-free behavioural model checked every cycle
// plus directed literal expectations for reset, fairness, wrap, back-pressure and drain.
module tb_rr_arb_mux_src;

   localparam int SW = 2;
   localparam int DW = 8;
   localparam int N  = 4;

   logic                 clk;
   logic                 rst;
   logic [N-1:0]         req;
   logic [N-1:0][DW-1:0] dat;
   logic [N-1:0]         gnt;
   logic [SW-1:0]        sel;
   logic [DW-1:0]        dout;
   logic                 vld;
   logic                 rdy;
`ifdef RR_ARB_MUX_SRC_STAT_EN
   logic [15:0]          cnt;
`endif

   int checks = 0;
   int errors = 0;
   bit started = 0;

   int m_vld = 0;
   int m_sel = 0;
   int m_dat = 0;
   int m_ptr = 0;
   int m_cnt = 0;

   rr_arb_mux_src #(.SEL_WIDTH(SW), .DAT_WIDTH(DW)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .req_i(req),
      .dat_i(dat),
      .gnt_o(gnt),
      .sel_o(sel),
      .dat_o(dout),
      .vld_o(vld),
      .rdy_i(rdy)
`ifdef RR_ARB_MUX_SRC_STAT_EN
      ,
      .cnt_o(cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // First requester at or after the pointer, counting around the ring; -1 when none.
   function automatic int model_winner();
      for (int off = 0; off < N; off++) begin
         int k;
         k = (m_ptr + off) % N;
         if (req[k]) return k;
      end
      return -1;
   endfunction

   function automatic int model_gnt();
      int k;
      if (rst) return 0;
      if (m_vld != 0 && !rdy) return 0;
      k = model_winner();
      if (k < 0) return 0;
      return 1 << k;
   endfunction

   // Model state advances at each rising edge from the inputs held across it.
   always @(posedge clk) begin
      int k;
      started = 1;
      if (rst) begin
         m_vld = 0; m_sel = 0; m_dat = 0; m_ptr = 0; m_cnt = 0;
      end else begin
         if (m_vld != 0 && rdy && m_cnt < 65535) m_cnt = m_cnt + 1;
         if (m_vld == 0 || rdy) begin
            k = model_winner();
            if (k >= 0) begin
               m_vld = 1;
               m_sel = k;
               m_dat = int'(dat[k]);
               m_ptr = (k + 1) % N;
            end else begin
               m_vld = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         checkOutput("model_gnt", 32'(gnt), 32'(model_gnt()));
         checkOutput("model_vld", 32'(vld), 32'(m_vld));
         checkOutput("model_sel", 32'(sel), 32'(m_sel));
         checkOutput("model_dat", 32'(dout), 32'(m_dat));
`ifdef RR_ARB_MUX_SRC_STAT_EN
         checkOutput("model_cnt", 32'(cnt), 32'(m_cnt));
`endif
      end
   end

   task automatic applyStimulus(input logic r, input logic [N-1:0] rq, input logic rd);
      @(posedge clk);
      #1;
      rst = r;
      req = rq;
      rdy = rd;
      @(negedge clk);
   endtask

   initial begin
      logic [N-1:0] exp_g [5];
      logic [DW-1:0] exp_d [4];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_d = '{8'h00, 8'h11, 8'h22, 8'h33};
      rst = 1'b1;
      req = 4'b1111;
      rdy = 1'b1;
      dat = {8'h33, 8'h22, 8'h11, 8'h00};

      // Reset held two cycles with everyone requesting.
      applyStimulus(1'b1, 4'b1111, 1'b1);
      checkOutput("rst_gnt0", 32'(gnt), 32'h0);
      applyStimulus(1'b1, 4'b1111, 1'b1);
      checkOutput("rst_gnt1", 32'(gnt), 32'h0);
      checkOutput("rst_vld", 32'(vld), 32'h0);
      checkOutput("rst_sel", 32'(sel), 32'h0);
      checkOutput("rst_dat", 32'(dout), 32'h0);

      // Fairness: all requesting, grants rotate 0..3 then back to 0.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 4'b1111, 1'b1);
         checkOutput("rr_gnt", 32'(gnt), 32'(exp_g[i]));
         if (i == 0) begin
            checkOutput("rr_vld_first", 32'(vld), 32'h0);
         end else begin
            checkOutput("rr_vld", 32'(vld), 32'h1);
            checkOutput("rr_dat", 32'(dout), 32'(exp_d[i-1]));
         end
      end
      applyStimulus(1'b0, 4'b0000, 1'b1);
      checkOutput("rr_dat_last", 32'(dout), 32'h00);
      checkOutput("rr_vld_last", 32'(vld), 32'h1);
      applyStimulus(1'b0, 4'b0000, 1'b1);
      checkOutput("rr_empty", 32'(vld), 32'h0);

      // Move pointer to 3 by granting index 2, then only requester 1 asks: wrap past 3.
      applyStimulus(1'b0, 4'b0100, 1'b1);
      checkOutput("wrap_setup_gnt", 32'(gnt), 32'b0100);
      applyStimulus(1'b0, 4'b0010, 1'b1);
      checkOutput("wrap_gnt", 32'(gnt), 32'b0010);
      checkOutput("wrap_setup_sel", 32'(sel), 32'h2);

      // Back-pressure for three cycles with requester 2 waiting.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 4'b0100, 1'b0);
         checkOutput("bp_gnt", 32'(gnt), 32'h0);
         checkOutput("bp_sel", 32'(sel), 32'h1);
         checkOutput("bp_dat", 32'(dout), 32'h11);
         checkOutput("bp_vld", 32'(vld), 32'h1);
      end
      applyStimulus(1'b0, 4'b0100, 1'b1);
      checkOutput("bp_release_gnt", 32'(gnt), 32'b0100);

      // Drain to empty: sel/dat keep the last word.
      applyStimulus(1'b0, 4'b0000, 1'b1);
      checkOutput("drain_sel", 32'(sel), 32'h2);
      checkOutput("drain_dat", 32'(dout), 32'h22);
      applyStimulus(1'b0, 4'b0000, 1'b1);
      checkOutput("drain_vld", 32'(vld), 32'h0);
      checkOutput("drain_sel_hold", 32'(sel), 32'h2);
      checkOutput("drain_dat_hold", 32'(dout), 32'h22);

      // Pointer now 3: first pick with everyone asking is requester 3.
      applyStimulus(1'b0, 4'b1111, 1'b1);
      checkOutput("ptr3_gnt", 32'(gnt), 32'b1000);

      // Reset mid-operation discards the word and returns the pointer to 0.
      applyStimulus(1'b1, 4'b1111, 1'b0);
      checkOutput("midrst_gnt", 32'(gnt), 32'h0);
      applyStimulus(1'b0, 4'b1111, 1'b1);
      checkOutput("midrst_vld", 32'(vld), 32'h0);
      checkOutput("midrst_gnt0", 32'(gnt), 32'b0001);

      // Mixed request/ready traffic checked by the model alone.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end

`ifdef RR_ARB_MUX_SRC_STAT_EN
      applyStimulus(1'b1, 4'b0000, 1'b1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'b1111, 1'b1);
      applyStimulus(1'b0, 4'b0000, 1'b1);
      applyStimulus(1'b0, 4'b0000, 1'b1);
      checkOutput("cnt_five", 32'(cnt), 32'd5);
      for (int i = 0; i < 65535; i++) applyStimulus(1'b0, 4'b1111, 1'b1);
      checkOutput("cnt_sat", 32'(cnt), 32'hFFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
